// File: rtl/spike_dec_pkg.sv
// ---------------------------------------------------------------------------
// spike_dec_pkg
//
// Shared definitions for the spike-rate decoder:
//   - dec_state_e      : decoder FSM state (IDLE / RUN)
//   - DEFAULT_CNT_W    : default spike-counter / rate width
//   - DEFAULT_WIN_W    : default window-length / timer width
//   - sat_inc()        : saturating increment used by every counter in the
//                        decoder. It works on a 32-bit carrier so callers of
//                        any width (up to 32) can share it; the caller passes
//                        its own ceiling and truncates the result back.
// ---------------------------------------------------------------------------
package spike_dec_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dec_state_e;

    localparam int DEFAULT_CNT_W = 8;
    localparam int DEFAULT_WIN_W = 8;

    // Adds inc to v, holding at maxv instead of wrapping.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic        inc,
        input logic [31:0] maxv
    );
        logic [31:0] r;
        r = v;
        if (inc && (v != maxv)) begin
            r = v + 32'd1;
        end
        return r;
    endfunction

endpackage : spike_dec_pkg

// File: rtl/spike_window_timer.sv
// ---------------------------------------------------------------------------
// spike_window_timer
//
// Holds the latched window length and the cycle timer of the current window,
// and flags the last cycle of each window with a one-cycle win_end_o pulse.
//
// A latched length of 0 stands for 2^WIN_W cycles. This falls out of the
// modular arithmetic: the last-cycle compare is timer == win - 1, and 0 - 1
// wraps to 2^WIN_W - 1.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   load_i       in   decoder is about to enter RUN: latch window_len_i and
//                     zero the timer
//   run_i        in   decoder is in RUN with ena high: advance the timer
//   window_len_i in   window length, sampled at each window start
//   win_end_o    out  high during the last cycle of the current window
// ---------------------------------------------------------------------------
module spike_window_timer
    import spike_dec_pkg::*;
#(
    parameter int WIN_W = DEFAULT_WIN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [WIN_W-1:0] window_len_i,
    output logic             win_end_o
);

    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] win_d;
    logic [WIN_W-1:0] timer_q;
    logic [WIN_W-1:0] timer_d;
    logic             last_cycle;

    assign last_cycle = (timer_q == (win_q - WIN_W'(1)));

    always_comb begin
        win_d     = win_q;
        timer_d   = timer_q;
        win_end_o = 1'b0;
        if (load_i) begin
            win_d   = window_len_i;
            timer_d = '0;
        end else if (run_i) begin
            if (last_cycle) begin
                // Back-to-back windows: the next one starts on the following
                // cycle with a freshly sampled length.
                win_end_o = 1'b1;
                timer_d   = '0;
                win_d     = window_len_i;
            end else begin
                timer_d = timer_q + WIN_W'(1);
            end
        end else begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= '0;
            timer_q <= '0;
        end else begin
            win_q   <= win_d;
            timer_q <= timer_d;
        end
    end

endmodule : spike_window_timer

// File: rtl/spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// spike_rate_decoder
//
// Turns a single-bit spike train (typically from an LIF neuron) back into a
// rate value. Rising edges of spike are counted over a programmable window
// of clock cycles. At the end of each window the count is presented on a
// valid/ready output, and the next window starts on the following cycle.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   ena         in   1: decode; 0: idle and discard any partial window
//   spike       in   spike level, sampled every cycle
//   window_len  in   window length in cycles (0 = 2^WIN_W), taken at the
//                    start of each window
//   rate_out    out  spike count of the last completed window
//   rate_valid  out  rate_out holds a result not yet accepted
//   rate_ready  in   consumer takes rate_out when rate_valid && rate_ready
//   saturated   out  last completed window's count clipped at 2^CNT_W-1
//   isi_out     out  (SPIKE_RATE_DECODER_ISI_EN only) cycles between the two
//                    most recent spike events, saturating
//   overrun     out  sticky: an unaccepted result was overwritten
//
// Optional build macro: SPIKE_RATE_DECODER_ISI_EN adds the inter-spike
// interval counter and the isi_out port.
// ---------------------------------------------------------------------------
module spike_rate_decoder
    import spike_dec_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W,
    parameter int WIN_W = DEFAULT_WIN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             saturated,
`ifdef SPIKE_RATE_DECODER_ISI_EN
    output logic [CNT_W-1:0] isi_out,
`endif
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    dec_state_e       state_q;
    dec_state_e       state_d;

    logic             spike_d_q;
    logic             spike_evt;

    logic [CNT_W-1:0] counter_q;
    logic [CNT_W-1:0] counter_d;
    logic             wsat_q;
    logic             wsat_d;

    logic [CNT_W-1:0] rate_out_q;
    logic [CNT_W-1:0] rate_out_d;
    logic             rate_valid_q;
    logic             rate_valid_d;
    logic             saturated_q;
    logic             saturated_d;
    logic             overrun_q;
    logic             overrun_d;

    logic             load_win;
    logic             run_active;
    logic             win_end;
    logic [CNT_W-1:0] cnt_inc;
    logic             sat_next;

    // A level held high counts once: only the low-to-high transition is an
    // event. spike_d_q tracks spike in every state, so an input that is
    // already high when RUN starts is not counted until it falls and rises.
    assign spike_evt = spike && !spike_d_q;

    assign load_win   = (state_q == IDLE) && ena;
    assign run_active = (state_q == RUN)  && ena;

    spike_window_timer #(
        .WIN_W (WIN_W)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load_win),
        .run_i        (run_active),
        .window_len_i (window_len),
        .win_end_o    (win_end)
    );

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ena)  state_d = RUN;
            RUN:     if (!ena) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Counter and result register
    // -----------------------------------------------------------------------
    // The count reported at window end includes an event in that last cycle,
    // so the result is taken from the incremented value, not from counter_q.
    assign cnt_inc  = CNT_W'(sat_inc(32'(counter_q), spike_evt, 32'(CNT_MAX)));
    assign sat_next = wsat_q || (spike_evt && (counter_q == CNT_MAX));

    always_comb begin
        counter_d    = '0;
        wsat_d       = 1'b0;
        rate_out_d   = rate_out_q;
        rate_valid_d = rate_valid_q;
        saturated_d  = saturated_q;
        overrun_d    = overrun_q;

        if (rate_valid_q && rate_ready) begin
            rate_valid_d = 1'b0;
        end

        if (run_active) begin
            if (win_end) begin
                rate_out_d   = cnt_inc;
                saturated_d  = sat_next;
                rate_valid_d = 1'b1;
                // An accept in the same cycle frees the slot, so only a
                // result that is still unaccepted is lost.
                if (rate_valid_q && !rate_ready) begin
                    overrun_d = 1'b1;
                end
            end else begin
                counter_d = cnt_inc;
                wsat_d    = sat_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_d_q    <= 1'b0;
            counter_q    <= '0;
            wsat_q       <= 1'b0;
            rate_out_q   <= '0;
            rate_valid_q <= 1'b0;
            saturated_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            spike_d_q    <= spike;
            counter_q    <= counter_d;
            wsat_q       <= wsat_d;
            rate_out_q   <= rate_out_d;
            rate_valid_q <= rate_valid_d;
            saturated_q  <= saturated_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rate_out   = rate_out_q;
    assign rate_valid = rate_valid_q;
    assign saturated  = saturated_q;
    assign overrun    = overrun_q;

`ifdef SPIKE_RATE_DECODER_ISI_EN
    // -----------------------------------------------------------------------
    // Inter-spike interval, free-running regardless of ena and windows
    // -----------------------------------------------------------------------
    // isi_cnt_q holds the number of cycles since the last event as seen in
    // the current cycle, so at the next event it is the interval itself.
    logic [CNT_W-1:0] isi_cnt_q;
    logic [CNT_W-1:0] isi_cnt_d;
    logic [CNT_W-1:0] isi_q;
    logic [CNT_W-1:0] isi_d;
    logic             isi_seen_q;
    logic             isi_seen_d;

    always_comb begin
        isi_cnt_d  = CNT_W'(sat_inc(32'(isi_cnt_q), 1'b1, 32'(CNT_MAX)));
        isi_d      = isi_q;
        isi_seen_d = isi_seen_q;
        if (spike_evt) begin
            if (isi_seen_q) begin
                isi_d = isi_cnt_q;
            end
            isi_seen_d = 1'b1;
            isi_cnt_d  = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isi_cnt_q  <= '0;
            isi_q      <= '0;
            isi_seen_q <= 1'b0;
        end else begin
            isi_cnt_q  <= isi_cnt_d;
            isi_q      <= isi_d;
            isi_seen_q <= isi_seen_d;
        end
    end

    assign isi_out = isi_q;
`endif

endmodule : spike_rate_decoder
